// File: rtl/imem_boot_loader_if.sv
// ----------------------------------------------------------------------------
// imem_boot_loader_if
// Groups the byte-stream, fetch-request and instruction-memory port signals
// of the boot loader. Signal names keep the direction suffix they have on the
// loader itself.
//   byte_valid_i / byte_i / byte_ready_o : program byte stream (valid/ready)
//   fetch_req_i / fetch_addr_i / fetch_gnt_o : fetch unit request path
//   mem_addr_o / mem_we_o / mem_wdata_o  : instruction memory port
// Modports:
//   slave  - the loader (consumes bytes and fetch requests, drives memory)
//   master - the surroundings (byte source, fetch unit, memory)
// ----------------------------------------------------------------------------
interface imem_boot_loader_if;
    logic        byte_valid_i;
    logic [7:0]  byte_i;
    logic        byte_ready_o;
    logic        fetch_req_i;
    logic [31:0] fetch_addr_i;
    logic        fetch_gnt_o;
    logic [31:0] mem_addr_o;
    logic        mem_we_o;
    logic [31:0] mem_wdata_o;

    modport slave (
        input  byte_valid_i,
        input  byte_i,
        output byte_ready_o,
        input  fetch_req_i,
        input  fetch_addr_i,
        output fetch_gnt_o,
        output mem_addr_o,
        output mem_we_o,
        output mem_wdata_o
    );

    modport master (
        output byte_valid_i,
        output byte_i,
        input  byte_ready_o,
        output fetch_req_i,
        output fetch_addr_i,
        input  fetch_gnt_o,
        input  mem_addr_o,
        input  mem_we_o,
        input  mem_wdata_o
    );
endinterface

// File: rtl/imem_boot_loader.sv
// ----------------------------------------------------------------------------
// imem_boot_loader
// Loads a program into instruction memory at boot. The program arrives as a
// little-endian byte stream: one 32-bit header word holding the word count N,
// followed by N instruction words. Each assembled word is written to
// BASE_ADDR + 4*i with a one-cycle write pulse while the core is held in
// reset. After the last word the memory address port is handed to the fetch
// unit and the core is released. A header count above NENTRIES parks the
// loader in an error state.
// Ports:
//   clk_i          clock
//   rst_i          synchronous active-high reset
//   bus            slave side of imem_boot_loader_if (bytes, fetch, memory)
//   core_rst_o     core held in reset while high
//   load_done_o    program loaded, core running
//   load_err_o     header count exceeded NENTRIES
//   words_loaded_o number of words written so far
// ----------------------------------------------------------------------------
module imem_boot_loader #(
    parameter int          NENTRIES  = 128,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    localparam int         CW        = $clog2(NENTRIES) + 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    imem_boot_loader_if.slave   bus,
    output logic                core_rst_o,
    output logic                load_done_o,
    output logic                load_err_o,
    output logic [CW-1:0]       words_loaded_o
);

    typedef enum logic [1:0] {
        HDR  = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t        r_state, r_state_next;
    logic [1:0]    r_byte_cnt, r_byte_cnt_next;
    logic [23:0]   r_asm, r_asm_next;          // bytes 0..2 of the word in progress
    logic [CW-1:0] r_count, r_count_next;      // header word count N
    logic [CW-1:0] r_words, r_words_next;      // words written so far
    logic          r_we, r_we_next;
    logic [31:0]   r_wdata, r_wdata_next;      // separate from r_asm so the next word can start during a write

    logic          w_accepting;
    logic          w_accept;
    logic [31:0]   w_word;
    logic [31:0]   w_load_addr;

    assign w_accepting = (r_state == HDR) || (r_state == LOAD);
    assign w_accept    = bus.byte_valid_i && w_accepting;
    // Complete word as it stands when the 4th byte is on the bus.
    assign w_word      = {bus.byte_i, r_asm};
    // During a write pulse r_words still holds the index of the word being
    // written, so one expression covers both the write and the idle address.
    assign w_load_addr = BASE_ADDR + 32'({r_words, 2'b00});

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= HDR;
            r_byte_cnt <= 2'd0;
            r_asm      <= 24'd0;
            r_count    <= '0;
            r_words    <= '0;
            r_we       <= 1'b0;
            r_wdata    <= 32'd0;
        end else begin
            r_state    <= r_state_next;
            r_byte_cnt <= r_byte_cnt_next;
            r_asm      <= r_asm_next;
            r_count    <= r_count_next;
            r_words    <= r_words_next;
            r_we       <= r_we_next;
            r_wdata    <= r_wdata_next;
        end
    end

    always_comb begin
        r_state_next    = r_state;
        r_byte_cnt_next = r_byte_cnt;
        r_asm_next      = r_asm;
        r_count_next    = r_count;
        r_words_next    = r_words;
        r_we_next       = 1'b0;
        r_wdata_next    = r_wdata;

        if (w_accept) begin
            r_byte_cnt_next = r_byte_cnt + 2'd1;
            case (r_byte_cnt)
                2'd0:    r_asm_next[7:0]   = bus.byte_i;
                2'd1:    r_asm_next[15:8]  = bus.byte_i;
                2'd2:    r_asm_next[23:16] = bus.byte_i;
                default: r_asm_next        = r_asm;
            endcase

            if (r_byte_cnt == 2'd3) begin
                if (r_state == HDR) begin
                    if (w_word == 32'd0) begin
                        r_state_next = RUN;
                    end else if (w_word > 32'(NENTRIES)) begin
                        r_state_next = ERR;
                    end else begin
                        r_state_next = LOAD;
                        r_count_next = w_word[CW-1:0];
                    end
                end else begin
                    r_we_next    = 1'b1;
                    r_wdata_next = w_word;
                end
            end
        end

        // The edge that ends a write pulse advances the word index; the last
        // word's pulse also hands the memory port over to the fetch unit.
        if (r_we) begin
            r_words_next = r_words + CW'(1);
            if ((r_words + CW'(1)) == r_count) begin
                r_state_next = RUN;
            end
        end
    end

    always_comb begin
        bus.byte_ready_o = w_accepting;
        bus.mem_we_o     = r_we;
        bus.mem_wdata_o  = r_wdata;
        bus.mem_addr_o   = w_load_addr;
        bus.fetch_gnt_o  = 1'b0;
        core_rst_o       = 1'b1;
        load_done_o      = 1'b0;
        load_err_o       = 1'b0;
        words_loaded_o   = r_words;

        case (r_state)
            RUN: begin
                bus.mem_addr_o  = bus.fetch_addr_i;
                bus.fetch_gnt_o = bus.fetch_req_i;
                core_rst_o      = 1'b0;
                load_done_o     = 1'b1;
            end
            ERR: begin
                load_err_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// ----------------------------------------------------------------------------
// tb_imem_boot_loader
// Bench for imem_boot_loader. Expected memory writes are queued when the
// corresponding data word is driven and compared by a monitor when the write
// pulse appears. Whole-stream cases come from a vector table; reset-state,
// write latency, mid-load reset and fetch pass-through are hand sequences.
// ----------------------------------------------------------------------------
module tb_imem_boot_loader;
    localparam int NENT = 128;
    localparam int CW   = $clog2(NENT) + 1;

    logic          clk;
    logic          rst;
    logic          core_rst;
    logic          load_done;
    logic          load_err;
    logic [CW-1:0] words;

    imem_boot_loader_if bus ();

    imem_boot_loader #(
        .NENTRIES  (NENT),
        .BASE_ADDR (32'h0)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .bus            (bus),
        .core_rst_o     (core_rst),
        .load_done_o    (load_done),
        .load_err_o     (load_err),
        .words_loaded_o (words)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]   addr;
        logic [31:0]   data;
        logic [CW-1:0] idx;
    } wr_t;

    typedef struct packed {
        logic [31:0]       hdr;
        logic [1:0]        ndata;
        logic [2:0][31:0]  data;
        logic              gaps;
        logic              exp_done;
        logic              exp_err;
        logic [CW-1:0]     exp_words;
    } vec_t;

    wr_t  exp_q[$];
    vec_t vecs[6];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h want=0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] hdr, input int nd,
                                input logic [31:0] d0, input logic [31:0] d1,
                                input logic [31:0] d2, input bit gaps,
                                input bit done, input bit err, input int nw);
        vec_t v;
        v.hdr       = hdr;
        v.ndata     = 2'(nd);
        v.data[0]   = d0;
        v.data[1]   = d1;
        v.data[2]   = d2;
        v.gaps      = gaps;
        v.exp_done  = done;
        v.exp_err   = err;
        v.exp_words = CW'(nw);
        return v;
    endfunction

    // Entered and left at posedge+1.
    task automatic do_reset();
        rst = 1'b1;
        bus.byte_valid_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Entered and left at posedge+1; optional idle gap before the byte.
    task automatic send_byte(input logic [7:0] b, input int gap);
        for (int g = 0; g < gap; g++) begin
            bus.byte_valid_i = 1'b0;
            @(posedge clk);
            #1;
        end
        bus.byte_valid_i = 1'b1;
        bus.byte_i       = b;
        @(posedge clk);
        #1;
        bus.byte_valid_i = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps);
        for (int k = 0; k < 4; k++) begin
            send_byte(w[8*k +: 8], gaps ? int'($urandom_range(0, 3)) : 0);
        end
    endtask

    task automatic push_write(input int i, input logic [31:0] d);
        wr_t e;
        e.addr = 32'h0 + 32'(4 * i);
        e.data = d;
        e.idx  = CW'(i);
        exp_q.push_back(e);
    endtask

    initial begin
        vecs[0] = mk(32'd2,   2, 32'h00500013, 32'h00100093, 32'h0,        1'b0, 1'b1, 1'b0, 2);
        vecs[1] = mk(32'd2,   2, 32'h00500013, 32'h00100093, 32'h0,        1'b1, 1'b1, 1'b0, 2);
        vecs[2] = mk(32'd0,   1, 32'hCAFEF00D, 32'h0,        32'h0,        1'b0, 1'b1, 1'b0, 0);
        vecs[3] = mk(32'd129, 1, 32'h12345678, 32'h0,        32'h0,        1'b0, 1'b0, 1'b1, 0);
        vecs[4] = mk(32'd3,   3, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 3);
        vecs[5] = mk(32'd128, 2, 32'h01020304, 32'h80706050, 32'h0,        1'b0, 1'b0, 1'b0, 2);

        rst              = 1'b1;
        bus.byte_valid_i = 1'b0;
        bus.byte_i       = 8'h00;
        bus.fetch_req_i  = 1'b0;
        bus.fetch_addr_i = 32'h0;

        // Write monitor: every pulse must match the head of the queue, carry
        // the pre-increment word count and last exactly one cycle.
        fork
            begin : monitor
                wr_t  e;
                logic prev_we;
                prev_we = 1'b0;
                forever begin
                    @(negedge clk);
                    if (rst) begin
                        prev_we = 1'b0;
                    end else begin
                        if (bus.mem_we_o) begin
                            if (exp_q.size() == 0) begin
                                total++;
                                bad++;
                                $display("FAIL unexpected_write: addr=0x%08h data=0x%08h want=no write",
                                         bus.mem_addr_o, bus.mem_wdata_o);
                            end else begin
                                e = exp_q.pop_front();
                                $display("write addr=0x%08h data=0x%08h words=%0d",
                                         bus.mem_addr_o, bus.mem_wdata_o, words);
                                check("wr_addr", bus.mem_addr_o, e.addr);
                                check("wr_data", bus.mem_wdata_o, e.data);
                                check("wr_words", 32'(words), 32'(e.idx));
                                check("we_one_cycle", 32'(prev_we), 32'd0);
                            end
                        end
                        prev_we = bus.mem_we_o;
                    end
                end
            end
        join_none

        // Reset state, with a fetch request that must not be granted.
        do_reset();
        bus.fetch_req_i = 1'b1;
        @(negedge clk);
        check("rst_byte_ready", 32'(bus.byte_ready_o), 32'd1);
        check("rst_we",         32'(bus.mem_we_o),     32'd0);
        check("rst_addr",       bus.mem_addr_o,        32'h0);
        check("rst_wdata",      bus.mem_wdata_o,       32'h0);
        check("rst_core_rst",   32'(core_rst),         32'd1);
        check("rst_done",       32'(load_done),        32'd0);
        check("rst_err",        32'(load_err),         32'd0);
        check("rst_gnt",        32'(bus.fetch_gnt_o),  32'd0);
        check("rst_words",      32'(words),            32'd0);
        $display("reset state checked");
        bus.fetch_req_i = 1'b0;
        @(posedge clk);
        #1;

        // Table-driven whole-stream cases.
        for (int v = 0; v < 6; v++) begin
            bit hdr_ok;
            do_reset();
            hdr_ok = (vecs[v].hdr != 32'd0) && (vecs[v].hdr <= 32'(NENT));
            send_word(vecs[v].hdr, vecs[v].gaps);
            for (int i = 0; i < int'(vecs[v].ndata); i++) begin
                if (hdr_ok && (32'(i) < vecs[v].hdr)) push_write(i, vecs[v].data[i]);
                send_word(vecs[v].data[i], vecs[v].gaps);
            end
            repeat (4) @(posedge clk);
            @(negedge clk);
            check("vec_done",       32'(load_done),        32'(vecs[v].exp_done));
            check("vec_err",        32'(load_err),         32'(vecs[v].exp_err));
            check("vec_core_rst",   32'(core_rst),         32'(!vecs[v].exp_done));
            check("vec_words",      32'(words),            32'(vecs[v].exp_words));
            check("vec_byte_ready", 32'(bus.byte_ready_o),
                  32'(!(vecs[v].exp_done || vecs[v].exp_err)));
            check("vec_all_writes", 32'(exp_q.size()),     32'd0);
            $display("vec %0d hdr=%0d done=%0b err=%0b words=%0d",
                     v, vecs[v].hdr, load_done, load_err, words);
            exp_q.delete();
            @(posedge clk);
            #1;
        end

        // Write latency: pulse the cycle after the last byte, RUN the next.
        do_reset();
        push_write(0, 32'hDEADBEEF);
        send_word(32'd1, 1'b0);
        send_word(32'hDEADBEEF, 1'b0);
        @(negedge clk);
        check("lat_we",       32'(bus.mem_we_o), 32'd1);
        check("lat_done_pre", 32'(load_done),    32'd0);
        check("lat_rst_pre",  32'(core_rst),     32'd1);
        @(negedge clk);
        check("lat_we_off",   32'(bus.mem_we_o), 32'd0);
        check("lat_done",     32'(load_done),    32'd1);
        check("lat_core_rst", 32'(core_rst),     32'd0);
        check("lat_words",    32'(words),        32'd1);
        $display("latency sequence checked");
        @(posedge clk);
        #1;

        // Reset after header + 5 data bytes, then a fresh one-word load.
        do_reset();
        push_write(0, 32'h00500013);
        send_word(32'd2, 1'b0);
        send_word(32'h00500013, 1'b0);
        send_byte(8'h93, 0);
        do_reset();
        @(negedge clk);
        check("mid_words",      32'(words),            32'd0);
        check("mid_addr",       bus.mem_addr_o,        32'h0);
        check("mid_byte_ready", 32'(bus.byte_ready_o), 32'd1);
        check("mid_core_rst",   32'(core_rst),         32'd1);
        @(posedge clk);
        #1;
        push_write(0, 32'h11223344);
        send_word(32'd1, 1'b0);
        send_word(32'h11223344, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("fresh_done",   32'(load_done),    32'd1);
        check("fresh_words",  32'(words),        32'd1);
        check("fresh_writes", 32'(exp_q.size()), 32'd0);
        $display("mid-load reset sequence checked");

        // Fetch pass-through in RUN.
        bus.fetch_req_i  = 1'b1;
        bus.fetch_addr_i = 32'h8;
        #1;
        check("run_addr",       bus.mem_addr_o,        32'h8);
        check("run_gnt",        32'(bus.fetch_gnt_o),  32'd1);
        check("run_we",         32'(bus.mem_we_o),     32'd0);
        check("run_byte_ready", 32'(bus.byte_ready_o), 32'd0);
        bus.fetch_req_i  = 1'b0;
        bus.fetch_addr_i = 32'h1234;
        #1;
        check("run_addr2", bus.mem_addr_o,       32'h1234);
        check("run_gnt0",  32'(bus.fetch_gnt_o), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("run_held", 32'(load_done), 32'd1);
        $display("fetch pass-through checked");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
